tty_tx_arb: RTL and testbench

//  Shares one teleprinter output channel (8-bit tto-style transmitter) between two character sources,
//  e.g. the IO-bus TTY and a panel/debug console. Round-robin arbitration, a valid/ready handshake per

---
 rtl/tty_tx_arb.sv | 163 ++++++++++++++++
 tb/tb_tty_tx_arb.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tty_tx_arb.sv
// tty_tx_arb: round-robin arbiter sharing one teleprinter transmitter between two character
// sources. Runs the clear / load / await-done sequence for each char, with a stuck-transmitter
// timeout and an optional idle gap after every char.
module tty_tx_arb #(
   parameter int unsigned TIMEOUT = 200000,
   parameter int unsigned GAP     = 0,
   parameter int unsigned TW      = 24
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [1:0] req_valid_i,
   input  logic [7:0] req_data0_i,
   input  logic [7:0] req_data1_i,
   output logic [1:0] req_ready_o,
   output logic [7:0] tx_data_o,
   output logic       tx_clr_o,
   output logic       tx_set_o,
   input  logic       tx_done_i,
   input  logic       err_clr_i,
   output logic [1:0] grant_o,
   output logic       busy_o,
   output logic       timeout_err_o
);

   // Terminal timer values; WAIT gives up on its TIMEOUT-th cycle, GAP lasts GAP+1 cycles.
   localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] GapLast     = TW'(GAP);

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StSet,
      StWait,
      StGap
   } state_e;

   state_e          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic [1:0]      grant_q, grant_d;
   logic [7:0]      char_q, char_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            done_prev_q, done_prev_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            err_q, err_d;

   logic            winner;
   logic            any_valid;
   logic            done_edge;

   // Pick the requesting source; on a tie the one that did not win last time goes first.
   always_comb begin
      any_valid = |req_valid_i;
      winner    = 1'b0;
      unique case (req_valid_i)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last_grant_q;
         default: winner = 1'b0;
      endcase
   end

   // done_prev is forced high on WAIT entry, so a done level left over from before is not an edge.
   assign done_edge = tx_done_i & ~done_prev_q;

   // Next-state and pulse outputs for the clear/load/await-done sequence.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      char_d       = char_q;
      tx_data_d    = tx_data_q;
      done_prev_d  = done_prev_q;
      timer_d      = timer_q;
      err_d        = err_q;
      req_ready_o  = 2'b00;
      tx_clr_o     = 1'b0;
      tx_set_o     = 1'b0;

      // A timeout raised below in the same cycle overrides this clear.
      if (err_clr_i) begin
         err_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (any_valid) begin
               req_ready_o[winner] = 1'b1;
               char_d              = winner ? req_data1_i : req_data0_i;
               grant_d             = winner ? 2'b10 : 2'b01;
               last_grant_d        = winner;
               state_d             = StClr;
            end
         end
         StClr: begin
            tx_clr_o  = 1'b1;
            // Present the char on tx_data in the same cycle as tx_set.
            tx_data_d = char_q;
            state_d   = StSet;
         end
         StSet: begin
            tx_set_o    = 1'b1;
            timer_d     = '0;
            done_prev_d = 1'b1;
            state_d     = StWait;
         end
         StWait: begin
            done_prev_d = tx_done_i;
            if (done_edge) begin
               timer_d = '0;
               state_d = StGap;
            end else if (timer_q == TimeoutLast) begin
               err_d   = 1'b1;
               timer_d = '0;
               state_d = StGap;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         StGap: begin
            if (timer_q == GapLast) begin
               timer_d = '0;
               grant_d = 2'b00;
               state_d = StIdle;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            grant_d = 2'b00;
            state_d = StIdle;
         end
      endcase
   end

   // State registers with synchronous reset; reset drops any char in flight.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         grant_q      <= 2'b00;
         char_q       <= 8'h00;
         tx_data_q    <= 8'h00;
         done_prev_q  <= 1'b0;
         timer_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         char_q       <= char_d;
         tx_data_q    <= tx_data_d;
         done_prev_q  <= done_prev_d;
         timer_q      <= timer_d;
         err_q        <= err_d;
      end
   end

   assign tx_data_o     = tx_data_q;
   assign grant_o       = grant_q;
   assign busy_o        = (state_q != StIdle);
   assign timeout_err_o = err_q;

endmodule

// File: tb/tb_tty_tx_arb.sv
// Bench for tty_tx_arb: scoreboard of expected chars checked at every tx_set, plus per-scenario
// timing checks. Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_tty_tx_arb;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req_valid;
   logic [7:0] req_data0;
   logic [7:0] req_data1;
   logic [1:0] req_ready;
   logic [7:0] tx_data;
   logic       tx_clr;
   logic       tx_set;
   logic       tx_done;
   logic       err_clr;
   logic [1:0] grant;
   logic       busy;
   logic       timeout_err;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   always #5 clk = ~clk;

   tty_tx_arb #(
      .TIMEOUT(100),
      .GAP    (10),
      .TW     (24)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .req_valid_i  (req_valid),
      .req_data0_i  (req_data0),
      .req_data1_i  (req_data1),
      .req_ready_o  (req_ready),
      .tx_data_o    (tx_data),
      .tx_clr_o     (tx_clr),
      .tx_set_o     (tx_set),
      .tx_done_i    (tx_done),
      .err_clr_i    (err_clr),
      .grant_o      (grant),
      .busy_o       (busy),
      .timeout_err_o(timeout_err)
   );

   // Scoreboard: every tx_set must carry the next expected char; ready must never be two-hot.
   always @(negedge clk) begin
      if (tx_set === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL tx_set_unexpected: got tx_set with tx_data=%h, required no tx_set",
                     tx_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (tx_data !== mon_exp) begin
               n_bad++;
               $display("FAIL tx_data_order: got %h, required %h", tx_data, mon_exp);
            end
         end
      end
      if (reset === 1'b0 && req_ready !== 2'b00) begin
         n_cmp++;
         if ((req_ready & (req_ready - 2'd1)) !== 2'b00) begin
            n_bad++;
            $display("FAIL ready_onehot: got %b, required at most one bit set", req_ready);
         end
      end
   end

   task automatic wait_ready(input int src, output bit found);
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (req_ready[src] === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_set(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx_set === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(output bit found);
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset;
      reset     = 1'b1;
      req_valid = 2'b00;
      req_data0 = 8'h00;
      req_data1 = 8'h00;
      tx_done   = 1'b0;
      err_clr   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({req_ready, tx_clr, tx_set} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_pulses: got ready/clr/set=%b, required 0000",
                  {req_ready, tx_clr, tx_set});
      end
      n_cmp++;
      if (tx_data !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_tx_data: got %h, required 00", tx_data);
      end
      n_cmp++;
      if ({grant, busy, timeout_err} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_status: got grant/busy/err=%b, required 0000",
                  {grant, busy, timeout_err});
      end
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_single;
      bit found;
      bit ok;
      exp_q.push_back(8'h41);
      req_data0 = 8'h41;
      req_valid = 2'b01;
      wait_ready(0, found);
      n_cmp++;
      if (found !== 1'b1 || req_ready !== 2'b01) begin
         n_bad++;
         $display("FAIL single_ready: got found=%b ready=%b, required 1 and 01", found, req_ready);
      end
      @(posedge clk);
      #1 req_valid = 2'b00;
      @(negedge clk);
      n_cmp++;
      if ({tx_clr, tx_set, grant} !== 4'b1001) begin
         n_bad++;
         $display("FAIL single_clr: got clr/set/grant=%b, required 1001", {tx_clr, tx_set, grant});
      end
      @(negedge clk);
      n_cmp++;
      if ({tx_clr, tx_set, tx_data} !== {2'b01, 8'h41}) begin
         n_bad++;
         $display("FAIL single_set: got clr/set=%b data=%h, required 01 and 41",
                  {tx_clr, tx_set}, tx_data);
      end
      repeat (50) @(posedge clk);
      #1 tx_done = 1'b1;
      ok = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (busy !== 1'b1 || grant !== 2'b01) ok = 1'b0;
      end
      n_cmp++;
      if (ok !== 1'b1) begin
         n_bad++;
         $display("FAIL single_hold: got busy=%b grant=%b, required 1 and 01 through GAP",
                  busy, grant);
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, grant, timeout_err} !== 4'b0000) begin
         n_bad++;
         $display("FAIL single_end: got busy/grant/err=%b, required 0000",
                  {busy, grant, timeout_err});
      end
      @(posedge clk);
      #1 tx_done = 1'b0;
   endtask

   task automatic test_fairness;
      bit         found;
      logic [1:0] want;
      do_reset();
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h31);
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h31);
      req_data0 = 8'h30;
      req_data1 = 8'h31;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         want  = (k % 2 == 0) ? 2'b01 : 2'b10;
         found = 1'b0;
         for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready !== 2'b00) begin
               found = 1'b1;
               break;
            end
         end
         n_cmp++;
         if (found !== 1'b1 || req_ready !== want) begin
            n_bad++;
            $display("FAIL fair_grant%0d: got ready=%b, required %b", k, req_ready, want);
         end
         if (k == 3) begin
            @(posedge clk);
            #1 req_valid = 2'b00;
         end
         wait_set(found);
         n_cmp++;
         if (found !== 1'b1) begin
            n_bad++;
            $display("FAIL fair_set%0d: got no tx_set, required one", k);
         end
         repeat (5) @(posedge clk);
         #1 tx_done = 1'b1;
         @(posedge clk);
         #1 tx_done = 1'b0;
      end
      wait_idle(found);
      n_cmp++;
      if (found !== 1'b1) begin
         n_bad++;
         $display("FAIL fair_idle: got busy=%b, required 0", busy);
      end
   endtask

   task automatic test_timeout;
      bit found;
      bit ok;
      exp_q.push_back(8'h55);
      @(posedge clk);
      #1 req_data0 = 8'h55;
      req_valid = 2'b01;
      wait_ready(0, found);
      @(posedge clk);
      #1 req_valid = 2'b00;
      wait_set(found);
      n_cmp++;
      if (found !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_set: got no tx_set, required one");
      end
      ok = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (busy !== 1'b1 || timeout_err !== 1'b0) ok = 1'b0;
      end
      n_cmp++;
      if (ok !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_early: got err=%b busy=%b, required 0 and 1 for 100 WAIT cycles",
                  timeout_err, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (timeout_err !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_flag: got %b, required 1", timeout_err);
      end
      repeat (11) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_idle: got busy=%b, required 0", busy);
      end
      @(posedge clk);
      #1 err_clr = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (timeout_err !== 1'b1) begin
         n_bad++;
         $display("FAIL errclr_hold: got %b, required 1 before the clear is sampled", timeout_err);
      end
      @(posedge clk);
      #1 err_clr = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (timeout_err !== 1'b0) begin
         n_bad++;
         $display("FAIL errclr_done: got %b, required 0", timeout_err);
      end
   endtask

   task automatic test_stuck_done;
      bit found;
      bit ok;
      tx_done = 1'b1;
      do_reset();
      exp_q.push_back(8'h7F);
      req_data1 = 8'h7F;
      req_valid = 2'b10;
      wait_ready(1, found);
      n_cmp++;
      if (found !== 1'b1) begin
         n_bad++;
         $display("FAIL stuck_ready: got ready=%b, required 10", req_ready);
      end
      @(posedge clk);
      #1 req_valid = 2'b00;
      wait_set(found);
      ok = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (busy !== 1'b1 || timeout_err !== 1'b0) ok = 1'b0;
      end
      n_cmp++;
      if (ok !== 1'b1) begin
         n_bad++;
         $display("FAIL stuck_false_done: got busy=%b err=%b, required WAIT held 100 cycles",
                  busy, timeout_err);
      end
      @(negedge clk);
      n_cmp++;
      if (timeout_err !== 1'b1) begin
         n_bad++;
         $display("FAIL stuck_timeout: got %b, required 1", timeout_err);
      end
      wait_idle(found);
      @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      exp_q.push_back(8'h7F);
      req_valid = 2'b10;
      wait_ready(1, found);
      @(posedge clk);
      #1 req_valid = 2'b00;
      wait_set(found);
      repeat (20) @(posedge clk);
      #1 tx_done = 1'b0;
      repeat (5) @(posedge clk);
      #1 tx_done = 1'b1;
      ok = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (busy !== 1'b1) ok = 1'b0;
      end
      @(negedge clk);
      n_cmp++;
      if (ok !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) begin
         n_bad++;
         $display("FAIL stuck_new_edge: got ok=%b busy=%b err=%b, required 1 0 0",
                  ok, busy, timeout_err);
      end
      @(posedge clk);
      #1 tx_done = 1'b0;
   endtask

   task automatic test_back_to_back;
      bit found;
      int cnt;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      req_data0 = 8'h11;
      req_valid = 2'b01;
      wait_ready(0, found);
      @(posedge clk);
      #1 req_data0 = 8'h22;
      wait_set(found);
      repeat (3) @(posedge clk);
      #1 tx_done = 1'b1;
      cnt   = 0;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cnt++;
         if (req_ready[0] === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      // Edge cycle, 11 GAP cycles (GAP+1), then the ready cycle.
      n_cmp++;
      if (found !== 1'b1 || cnt != 13) begin
         n_bad++;
         $display("FAIL b2b_gap: got ready %0d cycles after done, required 13", cnt);
      end
      @(posedge clk);
      #1 req_valid = 2'b00;
      tx_done = 1'b0;
      wait_set(found);
      repeat (3) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
      wait_idle(found);
      n_cmp++;
      if (found !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_idle: got busy=%b, required 0", busy);
      end
   endtask

   task automatic test_reset_mid;
      bit found;
      int sets;
      for (int c = 0; c < 2; c++) begin
         exp_q.push_back(c == 0 ? 8'h66 : 8'h77);
         @(posedge clk);
         #1 req_data0 = (c == 0) ? 8'h66 : 8'h77;
         req_valid = 2'b01;
         wait_ready(0, found);
         @(posedge clk);
         #1 req_valid = 2'b00;
         if (c == 0) begin
            wait_set(found);
            repeat (5) @(posedge clk);
         end else begin
            @(posedge clk);
         end
         // c==0: now in WAIT; c==1: now in SET.
         #1 reset = 1'b1;
         @(posedge clk);
         #1 reset = 1'b0;
         @(negedge clk);
         n_cmp++;
         if ({req_ready, tx_clr, tx_set, grant, busy, timeout_err, tx_data} !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_mid%0d: got ready=%b clr=%b set=%b grant=%b busy=%b data=%h",
                     c, req_ready, tx_clr, tx_set, grant, busy, tx_data);
         end
         sets = 0;
         repeat (20) begin
            @(negedge clk);
            if (tx_set === 1'b1) sets++;
         end
         n_cmp++;
         if (sets != 0) begin
            n_bad++;
            $display("FAIL reset_mid_reissue%0d: got %0d tx_set, required 0", c, sets);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_stuck_done();
      test_back_to_back();
      test_reset_mid();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d chars never sent, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
